// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the branch predictor: 2-bit direction counter
// encodings and their saturating update helpers.
package branch_predictor_pkg;

  typedef enum logic [1:0] {
    CNT_SNT = 2'b00,
    CNT_WNT = 2'b01,
    CNT_WT  = 2'b10,
    CNT_ST  = 2'b11
  } cnt_t;

  localparam cnt_t CNT_RESET = CNT_WNT;

  function automatic cnt_t cnt_inc(cnt_t c);
    return (c == CNT_ST) ? CNT_ST : cnt_t'(c + 2'd1);
  endfunction

  function automatic cnt_t cnt_dec(cnt_t c);
    return (c == CNT_SNT) ? CNT_SNT : cnt_t'(c - 2'd1);
  endfunction

  function automatic logic cnt_predicts_taken(cnt_t c);
    return (c == CNT_WT) || (c == CNT_ST);
  endfunction

endpackage

// File: rtl/branch_predictor_btb_table.sv
// Direct-mapped BTB storage: combinational lookup port and a synchronous
// resolve port that trains the 2-bit counters and allocates on taken misses.
module btb_table
  import branch_predictor_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int INDEX_BITS = 4
) (
  input  logic             clk,
  input  logic             reset,
  // word addresses (pc >> 2); the byte offset never selects an entry
  input  logic [WIDTH-3:0] rd_word,
  output logic             rd_hit,
  output cnt_t             rd_cnt,
  output logic [WIDTH-1:0] rd_target,
  input  logic             wr_en,
  input  logic [WIDTH-3:0] wr_word,
  input  logic             wr_taken,
  input  logic [WIDTH-1:0] wr_target
);

  localparam int ENTRIES  = 1 << INDEX_BITS;
  localparam int TAG_BITS = WIDTH - 2 - INDEX_BITS;

  logic                  valid_q  [ENTRIES];
  logic [TAG_BITS-1:0]   tag_q    [ENTRIES];
  logic [WIDTH-1:0]      target_q [ENTRIES];
  cnt_t                  cnt_q    [ENTRIES];

  logic [INDEX_BITS-1:0] rd_idx, wr_idx;
  logic [TAG_BITS-1:0]   rd_tag, wr_tag;
  logic                  wr_hit;

  assign rd_idx = rd_word[INDEX_BITS-1:0];
  assign rd_tag = rd_word[WIDTH-3:INDEX_BITS];
  assign wr_idx = wr_word[INDEX_BITS-1:0];
  assign wr_tag = wr_word[WIDTH-3:INDEX_BITS];

  assign rd_hit    = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign rd_cnt    = cnt_q[rd_idx];
  assign rd_target = target_q[rd_idx];
  assign wr_hit    = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);

  // Lookup reads the registered arrays, so a same-cycle update to the same
  // index is only visible from the next cycle on.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        cnt_q[i]    <= CNT_RESET;
      end
    end else if (wr_en) begin
      if (wr_hit) begin
        if (wr_taken) begin
          cnt_q[wr_idx]    <= cnt_inc(cnt_q[wr_idx]);
          target_q[wr_idx] <= wr_target;
        end else begin
          cnt_q[wr_idx] <= cnt_dec(cnt_q[wr_idx]);
        end
      end else if (wr_taken) begin
        valid_q[wr_idx]  <= 1'b1;
        tag_q[wr_idx]    <= wr_tag;
        target_q[wr_idx] <= wr_target;
        cnt_q[wr_idx]    <= CNT_WT;
      end
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Next-PC generator and EX-stage branch resolver. Recovery is encoded for a
// PC register that loads branch_pc when save_pc==0 and save_pc otherwise.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int INDEX_BITS = 4,
  parameter int PC_STEP    = 4,
  parameter int CNT_BITS   = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [WIDTH-1:0]    pc_add,
  output logic [WIDTH-1:0]    next_pc,
  output logic                pred_taken,
  input  logic                ex_valid,
  input  logic                ex_is_branch,
  input  logic [WIDTH-1:0]    ex_pc,
  input  logic                ex_taken,
  input  logic [WIDTH-1:0]    ex_target,
  input  logic                ex_pred_taken,
  input  logic [WIDTH-1:0]    ex_pred_target,
  output logic                flush,
  output logic [WIDTH-1:0]    branch_pc,
  output logic [WIDTH-1:0]    save_pc,
  output logic [CNT_BITS-1:0] mispredicts
);

  localparam logic [WIDTH-1:0] STEP = WIDTH'(PC_STEP);

  logic             rd_hit;
  cnt_t             rd_cnt;
  logic [WIDTH-1:0] rd_target;
  logic             br_valid;
  logic             mispredict;
  logic [WIDTH-1:0] fall_through;
  logic [CNT_BITS-1:0] mispredicts_q;

  btb_table #(
    .WIDTH      (WIDTH),
    .INDEX_BITS (INDEX_BITS)
  ) u_btb (
    .clk       (clk),
    .reset     (reset),
    .rd_word   (pc_add[WIDTH-1:2]),
    .rd_hit    (rd_hit),
    .rd_cnt    (rd_cnt),
    .rd_target (rd_target),
    .wr_en     (br_valid),
    .wr_word   (ex_pc[WIDTH-1:2]),
    .wr_taken  (ex_taken),
    .wr_target (ex_target)
  );

  assign pred_taken = rd_hit && cnt_predicts_taken(rd_cnt);
  assign next_pc    = pred_taken ? rd_target : (pc_add + STEP);

  assign br_valid     = ex_valid && ex_is_branch;
  assign fall_through = ex_pc + STEP;
  assign mispredict   = br_valid &&
                        ((ex_taken != ex_pred_taken) ||
                         (ex_taken && (ex_target != ex_pred_target)));
  assign flush        = mispredict && !reset;

  // A not-taken branch at the top of memory falls through to 0; save_pc==0
  // with branch_pc==0 still makes the PC register load address 0.
  always_comb begin
    branch_pc = '0;
    save_pc   = '0;
    if (mispredict) begin
      if (ex_taken) begin
        branch_pc = ex_target;
      end else begin
        save_pc = fall_through;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mispredicts_q <= '0;
    end else if (flush && (mispredicts_q != '1)) begin
      mispredicts_q <= mispredicts_q + 1'b1;
    end
  end

  assign mispredicts = mispredicts_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: hand-computed expectations checked
// with immediate assertions at each step, then one summary line.
module tb_branch_predictor;

  logic        clk;
  logic        reset;
  logic [31:0] pc_add;
  logic [31:0] next_pc;
  logic        pred_taken;
  logic        ex_valid;
  logic        ex_is_branch;
  logic [31:0] ex_pc;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        flush;
  logic [31:0] branch_pc;
  logic [31:0] save_pc;
  logic [15:0] mispredicts;

  int vectors;
  int miscompares;

  branch_predictor dut (
    .clk            (clk),
    .reset          (reset),
    .pc_add         (pc_add),
    .next_pc        (next_pc),
    .pred_taken     (pred_taken),
    .ex_valid       (ex_valid),
    .ex_is_branch   (ex_is_branch),
    .ex_pc          (ex_pc),
    .ex_taken       (ex_taken),
    .ex_target      (ex_target),
    .ex_pred_taken  (ex_pred_taken),
    .ex_pred_target (ex_pred_target),
    .flush          (flush),
    .branch_pc      (branch_pc),
    .save_pc        (save_pc),
    .mispredicts    (mispredicts)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // checker
  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
      $error("miscompare on %s", tag);
    end
  endtask

  // drivers
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    ex_valid       = 1'b0;
    ex_is_branch   = 1'b0;
    ex_pc          = 32'h0;
    ex_taken       = 1'b0;
    ex_target      = 32'h0;
    ex_pred_taken  = 1'b0;
    ex_pred_target = 32'h0;
  endtask

  task automatic branch(input logic [31:0] pc, input logic taken,
                        input logic [31:0] target, input logic ptaken,
                        input logic [31:0] ptarget);
    ex_valid       = 1'b1;
    ex_is_branch   = 1'b1;
    ex_pc          = pc;
    ex_taken       = taken;
    ex_target      = target;
    ex_pred_taken  = ptaken;
    ex_pred_target = ptarget;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset  = 1'b1;
    pc_add = 32'h0;
    idle();
    tick();
    tick();
    reset = 1'b0;

    // 1: post-reset sequential fetch
    pc_add = 32'h40;
    #1;
    check("reset_next_pc", next_pc, 32'h44);
    check("reset_pred", {31'b0, pred_taken}, 32'h0);
    check("reset_mispredicts", {16'b0, mispredicts}, 32'h0);
    check("reset_flush", {31'b0, flush}, 32'h0);

    // 2: taken branch mispredicted as not taken; lookup has no bypass
    branch(32'h40, 1'b1, 32'h10, 1'b0, 32'h44);
    #1;
    check("t2_flush", {31'b0, flush}, 32'h1);
    check("t2_branch_pc", branch_pc, 32'h10);
    check("t2_save_pc", save_pc, 32'h0);
    check("t2_no_bypass", next_pc, 32'h44);
    tick();
    idle();
    #1;
    check("t2_next_pc", next_pc, 32'h10);
    check("t2_pred", {31'b0, pred_taken}, 32'h1);
    check("t2_mispredicts", {16'b0, mispredicts}, 32'h1);

    // 4: alias at same index, different tag
    pc_add = 32'h80;
    #1;
    check("alias_next_pc", next_pc, 32'h84);
    check("alias_pred", {31'b0, pred_taken}, 32'h0);

    // non-branch and invalid slots never flush or train
    pc_add = 32'h40;
    branch(32'h40, 1'b0, 32'h0, 1'b1, 32'h10);
    ex_is_branch = 1'b0;
    #1;
    check("nobranch_flush", {31'b0, flush}, 32'h0);
    ex_is_branch = 1'b1;
    ex_valid     = 1'b0;
    #1;
    check("invalid_flush", {31'b0, flush}, 32'h0);
    tick();
    idle();
    #1;
    check("invalid_no_train", next_pc, 32'h10);

    // 3: not taken, predicted taken -> fall-through recovery, WT->WNT
    branch(32'h40, 1'b0, 32'h10, 1'b1, 32'h10);
    #1;
    check("t3_flush", {31'b0, flush}, 32'h1);
    check("t3_save_pc", save_pc, 32'h44);
    check("t3_branch_pc", branch_pc, 32'h0);
    tick();
    idle();
    #1;
    check("t3_next_pc", next_pc, 32'h44);
    check("t3_pred", {31'b0, pred_taken}, 32'h0);
    check("t3_mispredicts", {16'b0, mispredicts}, 32'h2);

    // 6: four correct taken resolves, WNT->WT->ST->ST->ST, no flush
    for (int i = 0; i < 4; i++) begin
      branch(32'h40, 1'b1, 32'h10, 1'b1, 32'h10);
      #1;
      check("t6_correct_flush", {31'b0, flush}, 32'h0);
      tick();
    end
    idle();
    #1;
    check("t6_mispredicts", {16'b0, mispredicts}, 32'h2);
    branch(32'h40, 1'b0, 32'h10, 1'b1, 32'h10);
    #1;
    check("t6_nt_flush", {31'b0, flush}, 32'h1);
    tick();
    idle();
    #1;
    check("t6_st_to_wt_next_pc", next_pc, 32'h10);
    check("t6_st_to_wt_pred", {31'b0, pred_taken}, 32'h1);
    check("t6_mispredicts_after", {16'b0, mispredicts}, 32'h3);

    // taken with wrong target while direction matched
    branch(32'h40, 1'b1, 32'h20, 1'b1, 32'h10);
    #1;
    check("tgt_flush", {31'b0, flush}, 32'h1);
    check("tgt_branch_pc", branch_pc, 32'h20);
    tick();
    idle();
    #1;
    check("tgt_next_pc", next_pc, 32'h20);
    check("tgt_mispredicts", {16'b0, mispredicts}, 32'h4);

    // 5: wrap to zero, then concurrent reset suppresses flush and clears table
    branch(32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 32'h100);
    #1;
    check("wrap_flush", {31'b0, flush}, 32'h1);
    check("wrap_save_pc", save_pc, 32'h0);
    check("wrap_branch_pc", branch_pc, 32'h0);
    reset = 1'b1;
    #1;
    check("wrap_reset_flush", {31'b0, flush}, 32'h0);
    tick();
    reset = 1'b0;
    idle();
    #1;
    check("cleared_next_pc", next_pc, 32'h44);
    check("cleared_pred", {31'b0, pred_taken}, 32'h0);
    check("cleared_mispredicts", {16'b0, mispredicts}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
Next-PC generator and branch resolver that drives the PC register stage. It predicts direction and target for the current fetch PC using a direct-mapped BTB with 2-bit saturating counters, and produces next_pc. It takes branch outcomes from EX and, on a mispredict, raises flush with the recovery address encoded as branch_pc/save_pc. The PC register rule it targets is: on flush, load branch_pc if save_pc==0, otherwise load save_pc.

Parameters:
WIDTH, 32, PC/address width in bits
INDEX_BITS, 4, log2 of BTB entries (16 entries)
PC_STEP, 4, sequential PC increment
CNT_BITS, 16, width of the mispredict performance counter

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
pc_add  in  WIDTH  current fetch PC from the PC register
next_pc  out  WIDTH  predicted next fetch PC
pred_taken  out  1  prediction for pc_add; travels down the pipe with the instruction
ex_valid  in  1  EX stage holds a valid instruction
ex_is_branch  in  1  EX instruction is a conditional branch
ex_pc  in  WIDTH  PC of the EX instruction
ex_taken  in  1  resolved direction
ex_target  in  WIDTH  resolved taken target
ex_pred_taken  in  1  prediction made at fetch for this instruction
ex_pred_target  in  WIDTH  next_pc predicted at fetch for this instruction
flush  out  1  mispredict; PC register must redirect
branch_pc  out  WIDTH  recovery target, used when save_pc==0
save_pc  out  WIDTH  recovery fall-through, 0 when branch_pc is to be used
mispredicts  out  CNT_BITS  saturating mispredict count

Behaviour:
- Reset (synchronous, active-high) clears all valid bits, sets all counters to WNT (01), and clears mispredicts to 0. flush is forced to 0 while reset=1.
- Index = pc[INDEX_BITS+1:2]. Tag = pc[WIDTH-1:INDEX_BITS+2].
- Each entry holds valid, tag, target[WIDTH], and a 2-bit counter: SNT=00, WNT=01, WT=10, ST=11.
- Lookup is combinational from pc_add.
  - Hit = valid and tag match.
  - pred_taken = hit and counter[1].
  - next_pc = pred_taken ? target : pc_add+PC_STEP, computed modulo 2^WIDTH.
- Resolution is combinational, active when ex_valid and ex_is_branch.
  - Mispredict if ex_taken!=ex_pred_taken, or if ex_taken and ex_target!=ex_pred_target.
  - flush = mispredict and not reset.
  - Actually taken: branch_pc=ex_target, save_pc=0.
  - Actually not taken: save_pc=ex_pc+PC_STEP. Wrap case: if that sum is 0, save_pc=0 and branch_pc=0, so the PC register still loads 0.
  - No mispredict, or no valid branch: flush=0, branch_pc=0, save_pc=0.
- Table update at posedge clk, when ex_valid and ex_is_branch, indexed by ex_pc.
  - Hit, taken: counter saturating-increments (ST stays ST); target<=ex_target.
  - Hit, not taken: counter saturating-decrements (SNT stays SNT); target unchanged.
  - Miss, taken: allocate by overwriting the entry. Set valid=1, tag, target=ex_target, counter=WT.
  - Miss, not taken: no change.
- Same-cycle lookup and update to the same index: the lookup sees pre-update contents. There is no bypass.
- mispredicts increments on each cycle flush=1 and saturates at all-ones.
- ex_valid=0 or ex_is_branch=0: no update and no flush.
- Reset asserted mid-operation overrides any update in that cycle.

Decomposition:
- Shared package holds the counter encodings SNT/WNT/WT/ST and the reset counter value WNT.
- One sub-module, btb_table: entry storage, combinational read port, synchronous write port with the saturating-counter update.
- The top level holds lookup muxing, mispredict detection, recovery encoding and the perf counter.

Test Plan:
1. Reset, then pc_add=0x40 -> next_pc=0x44, pred_taken=0, mispredicts=0.
2. Branch at 0x40 taken to 0x10, predicted not taken (ex_pred_target=0x44) -> same cycle flush=1, branch_pc=0x10, save_pc=0. Next cycle pc_add=0x40 -> next_pc=0x10, pred_taken=1; mispredicts=1.
3. Continue from 2: branch at 0x40 not taken, predicted taken -> flush=1, save_pc=0x44. Counter WT->WNT, so pc_add=0x40 then gives next_pc=0x44.
4. Alias check after 2: pc_add=0x80 (same index, different tag) -> miss, next_pc=0x84, pred_taken=0.
5. Wrap: branch at 0xFFFFFFFC predicted taken, not taken -> flush=1, save_pc=0, branch_pc=0. Concurrent reset=1 forces flush=0 and clears the table.
6. Four correct taken resolves at 0x40 -> counter ST, flush=0 each time. One not-taken (flush=1) leaves WT, so pc_add=0x40 still predicts 0x10. Correctly predicted branches do not increment mispredicts.
